clkdiv_cfg_ctrl: RTL and testbench
==================================

Name: clkdiv_cfg_ctrl

Overview:
- Reconfiguration controller placed in front of the ClkDiv integer clock divider.
- Shares the divider's ratio input between two requesters (e.g. UART baud control and a debug/CSR path) using round-robin arbitration.
- Sequences every ratio change glitch-safely:
  - gate the divider off;
  - wait a guard period;
  - load the new ratio;
  - settle;
  - re-enable;
  - acknowledge the requester.
- Drives the divider's clock-enable and ratio inputs directly.

Parameters:
- RATIO_WIDTH, 8, width of the ratio fields; matches the divider's ratio input.
- DEFAULT_RATIO, 2, value of o_div_ratio after reset.
- GUARD_CYCLES, 4, cycles o_clk_en is held low before a ratio load; must be >=1.
- SETTLE_CYCLES, 2, cycles after the load before re-enable and ack; must be >=1.

Ports:
- i_ref_clk  in  1  reference clock; the same clock that feeds the divider.
- i_rst  in  1  asynchronous, active-high reset.
- i_en  in  1  requested divider enable, applied while the controller is idle.
- i_req0  in  1  requester 0 ratio-change request (level).
- i_ratio0  in  RATIO_WIDTH  requester 0 new ratio; must be stable while i_req0 is high.
- o_ack0  out  1  one-cycle completion pulse to requester 0.
- i_req1  in  1  requester 1 request.
- i_ratio1  in  RATIO_WIDTH  requester 1 new ratio.
- o_ack1  out  1  one-cycle completion pulse to requester 1.
- o_div_ratio  out  RATIO_WIDTH  registered ratio driven to the divider.
- o_clk_en  out  1  registered enable driven to the divider.
- o_busy  out  1  high in every state except IDLE.
- o_err  out  1  rejected-ratio flag; see Optional Feature.

Behaviour:
- Reset (async, i_rst=1):
  - state IDLE, round-robin pointer = 0 (requester 0 preferred);
  - o_div_ratio = DEFAULT_RATIO;
  - o_clk_en = 0, o_ack0 = 0, o_ack1 = 0, o_busy = 0, o_err = 0;
  - all counters cleared.
- Reset mid-sequence aborts the sequence. No ack is issued; the requester must re-request.
- States: IDLE, DRAIN, LOAD, SETTLE, ACK. All outputs are registered.
- IDLE:
  - o_clk_en <= i_en, i.e. one-cycle latency.
  - If any i_reqN is high, grant one requester:
    - only one requesting: grant it;
    - both requesting: grant the one the pointer favours, then point the pointer at the other.
  - At the grant, latch the granted ratio and the source id.
- Next state after a grant:
  - latched ratio == o_div_ratio: go straight to ACK; o_clk_en is not disturbed.
  - otherwise: go to DRAIN.
- DRAIN: o_clk_en <= 0. Stay GUARD_CYCLES cycles, then go to LOAD.
- LOAD: o_div_ratio <= latched ratio. Stay one cycle, then go to SETTLE.
- SETTLE: o_clk_en stays 0. Stay SETTLE_CYCLES cycles, then go to ACK.
- ACK:
  - o_ackN = 1 for the latched source, for exactly one cycle;
  - o_clk_en <= i_en;
  - next state IDLE.
- Latency, with the grant taken on edge 0:
  - DRAIN occupies cycles 1..G;
  - LOAD is cycle G+1; new o_div_ratio is visible from cycle G+2;
  - ack is high in cycle G+S+2.
  - Defaults (G=4, S=2): ack in cycle 8.
- Handshake:
  - The requester holds i_reqN and i_ratioN stable until it sees the ack.
  - It deasserts i_reqN in the cycle after the ack.
  - i_reqN still high in the first IDLE cycle after its ack is treated as a new request.
- Changes on i_en while busy are ignored until ACK. ACK samples i_en.
- A request arriving while busy waits; it is arbitrated on return to IDLE.
- Internal counters are $clog2(max(GUARD_CYCLES, SETTLE_CYCLES)+1) bits wide.

Optional Feature:
- Macro: CLKDIV_RATIO_CHECK_EN.
- Defined:
  - A granted ratio < 2 (0 or 1) is rejected and goes directly to ACK.
  - o_err = 1 in the same cycle as o_ackN.
  - o_div_ratio and o_clk_en are unchanged.
- Undefined:
  - Every ratio is accepted and sequenced normally.
  - o_err is tied to 0.

Test Plan:
- Reset with i_en=1, then idle: o_div_ratio=2, and o_clk_en=1 one cycle after reset release. Assert i_rst mid-cycle: all outputs return to reset values immediately.
- i_req0=1, i_ratio0=8 (defaults): o_busy=1 from cycle 1; o_clk_en=0 in cycles 1-7; o_div_ratio=8 from cycle 6; o_ack0 high only in cycle 8; o_clk_en=1 in cycle 9.
- i_req0 and i_req1 asserted in the same cycle (ratios 32 and 8):
  - requester 0 is served first (ack at cycle 8), then requester 1;
  - final o_div_ratio=8;
  - the next simultaneous pair is served requester 1 first.
- Request with ratio equal to the current o_div_ratio (2): ack one cycle after the grant; o_clk_en stays high throughout.
- i_rst asserted during DRAIN: no ack is issued; o_div_ratio=2, state IDLE. A re-request completes normally.
- With CLKDIV_RATIO_CHECK_EN defined, i_ratio1=1: o_ack1 and o_err are both high in one cycle, and o_div_ratio is unchanged. Without the macro, the same stimulus loads ratio 1 and o_err stays 0.

Source files
------------

// File: rtl/clkdiv_cfg_ctrl.sv
// Round-robin ratio reconfiguration controller for the ClkDiv divider (optional CLKDIV_RATIO_CHECK_EN rejects ratios < 2).
// Latency: ack GUARD_CYCLES+SETTLE_CYCLES+2 cycles after grant for a ratio change, 1 cycle for an unchanged/rejected ratio.
// Backpressure: level requests are held off while busy and arbitrated on return to idle; ack is a one-cycle pulse.
module clkdiv_cfg_ctrl #(
    parameter int RATIO_WIDTH   = 8,
    parameter int DEFAULT_RATIO = 2,
    parameter int GUARD_CYCLES  = 4,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                   i_ref_clk,
    input  logic                   i_rst,
    input  logic                   i_en,
    input  logic                   i_req0,
    input  logic [RATIO_WIDTH-1:0] i_ratio0,
    output logic                   o_ack0,
    input  logic                   i_req1,
    input  logic [RATIO_WIDTH-1:0] i_ratio1,
    output logic                   o_ack1,
    output logic [RATIO_WIDTH-1:0] o_div_ratio,
    output logic                   o_clk_en,
    output logic                   o_busy,
    output logic                   o_err
);

    localparam int MAX_CYCLES = (GUARD_CYCLES > SETTLE_CYCLES) ? GUARD_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] GUARD_LAST  = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_LOAD,
        ST_SETTLE,
        ST_ACK
    } state_t;

    state_t                 state;
    logic                   rr_ptr;
    logic                   src_q;
    logic [RATIO_WIDTH-1:0] ratio_q;
    logic [CNT_W-1:0]       cnt;

    logic                   grant_vld;
    logic                   grant_src;
    logic                   both_req;
    logic [RATIO_WIDTH-1:0] grant_ratio;
    logic                   ratio_bad;

    always_comb begin
        grant_vld = i_req0 | i_req1;
        both_req  = i_req0 & i_req1;
        grant_src = 1'b0;
        if (both_req) begin
            grant_src = rr_ptr;
        end else if (i_req1) begin
            grant_src = 1'b1;
        end
        grant_ratio = grant_src ? i_ratio1 : i_ratio0;
    end

`ifdef CLKDIV_RATIO_CHECK_EN
    // Ratios 0 and 1 would stall or bypass the divider, so they never reach it.
    assign ratio_bad = (grant_ratio < RATIO_WIDTH'(2));
`else
    assign ratio_bad = 1'b0;
    assign o_err     = 1'b0;
`endif

    always_ff @(posedge i_ref_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            rr_ptr      <= 1'b0;
            src_q       <= 1'b0;
            ratio_q     <= '0;
            cnt         <= '0;
            o_div_ratio <= RATIO_WIDTH'(DEFAULT_RATIO);
            o_clk_en    <= 1'b0;
            o_ack0      <= 1'b0;
            o_ack1      <= 1'b0;
            o_busy      <= 1'b0;
`ifdef CLKDIV_RATIO_CHECK_EN
            o_err       <= 1'b0;
`endif
        end else begin
            o_ack0 <= 1'b0;
            o_ack1 <= 1'b0;
`ifdef CLKDIV_RATIO_CHECK_EN
            o_err  <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    o_clk_en <= i_en;
                    o_busy   <= 1'b0;
                    if (grant_vld) begin
                        src_q   <= grant_src;
                        ratio_q <= grant_ratio;
                        cnt     <= '0;
                        o_busy  <= 1'b1;
                        if (both_req) begin
                            rr_ptr <= ~grant_src;
                        end
                        // Nothing to reprogram: acknowledge without gating the divider.
                        if (ratio_bad || (grant_ratio == o_div_ratio)) begin
                            state  <= ST_ACK;
                            o_ack0 <= ~grant_src;
                            o_ack1 <= grant_src;
`ifdef CLKDIV_RATIO_CHECK_EN
                            o_err  <= ratio_bad;
`endif
                        end else begin
                            state    <= ST_DRAIN;
                            o_clk_en <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    o_clk_en <= 1'b0;
                    if (cnt == GUARD_LAST) begin
                        cnt   <= '0;
                        state <= ST_LOAD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_LOAD: begin
                    o_clk_en    <= 1'b0;
                    o_div_ratio <= ratio_q;
                    state       <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    o_clk_en <= 1'b0;
                    if (cnt == SETTLE_LAST) begin
                        state  <= ST_ACK;
                        o_ack0 <= ~src_q;
                        o_ack1 <= src_q;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_ACK: begin
                    o_clk_en <= i_en;
                    o_busy   <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clkdiv_cfg_ctrl.sv
// Bench for clkdiv_cfg_ctrl: directed scenarios plus random requesters, checked every cycle
// against a timestamp-based model of grant / load / ack times.
module tb_clkdiv_cfg_ctrl;

    localparam int W   = 8;
    localparam int DEF = 2;
    localparam int G   = 4;
    localparam int S   = 2;
`ifdef CLKDIV_RATIO_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic         ref_clk;
    logic         i_rst;
    logic         i_en;
    logic         i_req0;
    logic [W-1:0] i_ratio0;
    logic         o_ack0;
    logic         i_req1;
    logic [W-1:0] i_ratio1;
    logic         o_ack1;
    logic [W-1:0] o_div_ratio;
    logic         o_clk_en;
    logic         o_busy;
    logic         o_err;

    clkdiv_cfg_ctrl #(
        .RATIO_WIDTH  (W),
        .DEFAULT_RATIO(DEF),
        .GUARD_CYCLES (G),
        .SETTLE_CYCLES(S)
    ) dut (
        .i_ref_clk  (ref_clk),
        .i_rst      (i_rst),
        .i_en       (i_en),
        .i_req0     (i_req0),
        .i_ratio0   (i_ratio0),
        .o_ack0     (o_ack0),
        .i_req1     (i_req1),
        .i_ratio1   (i_ratio1),
        .o_ack1     (o_ack1),
        .o_div_ratio(o_div_ratio),
        .o_clk_en   (o_clk_en),
        .o_busy     (o_busy),
        .o_err      (o_err)
    );

    initial ref_clk = 1'b0;
    always #5 ref_clk = ~ref_clk;

    int n_chk = 0;
    int n_bad = 0;
    logic done;
    logic rand_stop;

    // Reference model: expected outputs for the current cycle plus event timestamps.
    logic [W-1:0] exp_ratio;
    logic         exp_en, exp_busy, exp_ack0, exp_ack1, exp_err;
    int           m_edge, m_next, m_load, m_ack, m_src, m_rr;
    logic [W-1:0] m_pend;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic ratio_rejected(input logic [W-1:0] r);
        return CHECK_EN && (r < 8'd2);
    endfunction

    task automatic model_reset();
        exp_ratio = W'(DEF);
        exp_en    = 1'b0;
        exp_busy  = 1'b0;
        exp_ack0  = 1'b0;
        exp_ack1  = 1'b0;
        exp_err   = 1'b0;
        m_edge    = 0;
        m_next    = 0;
        m_load    = 0;
        m_ack     = 0;
        m_src     = 0;
        m_rr      = 0;
        m_pend    = '0;
    endtask

    // Called once per rising edge; computes what the next cycle must show.
    task automatic model_step();
        int           src;
        int           c;
        logic [W-1:0] r;
        logic         bad;
        if (i_rst) begin
            model_reset();
            return;
        end
        m_edge++;
        exp_ack0 = 1'b0;
        exp_ack1 = 1'b0;
        exp_err  = 1'b0;
        if (m_edge >= m_next) begin
            exp_en   = i_en;
            exp_busy = 1'b0;
            if (i_req0 || i_req1) begin
                if (i_req0 && i_req1) begin
                    src  = m_rr;
                    m_rr = 1 - src;
                end else begin
                    src = i_req1 ? 1 : 0;
                end
                r        = (src == 1) ? i_ratio1 : i_ratio0;
                bad      = ratio_rejected(r);
                m_src    = src;
                exp_busy = 1'b1;
                if (bad || r == exp_ratio) begin
                    exp_ack0 = (src == 0);
                    exp_ack1 = (src == 1);
                    exp_err  = bad;
                    m_next   = m_edge + 2;
                end else begin
                    exp_en = 1'b0;
                    m_pend = r;
                    m_load = m_edge + G + 2;
                    m_ack  = m_edge + G + S + 2;
                    m_next = m_ack + 1;
                end
            end
        end else begin
            c = m_edge + 1;
            if (c == m_next) begin
                exp_busy = 1'b0;
                exp_en   = i_en;
            end else begin
                exp_busy = 1'b1;
                exp_en   = 1'b0;
                if (c == m_load) exp_ratio = m_pend;
                if (c == m_ack) begin
                    exp_ack0 = (m_src == 0);
                    exp_ack1 = (m_src == 1);
                end
            end
        end
    endtask

    task automatic cycle_checks();
        chk("div_ratio", o_div_ratio, exp_ratio);
        chk("clk_en", o_clk_en, exp_en);
        chk("busy", o_busy, exp_busy);
        chk("ack0", o_ack0, exp_ack0);
        chk("ack1", o_ack1, exp_ack1);
        chk("err", o_err, exp_err);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ratio"}, o_div_ratio, DEF);
        chk({tag, "_en"}, o_clk_en, 1'b0);
        chk({tag, "_busy"}, o_busy, 1'b0);
        chk({tag, "_ack0"}, o_ack0, 1'b0);
        chk({tag, "_ack1"}, o_ack1, 1'b0);
        chk({tag, "_err"}, o_err, 1'b0);
    endtask

    // Caller has just raised the request within the cycle before the grant edge.
    task automatic wait_ack(input int id, output int lat, output logic err_at,
                            output logic other, output logic en_all);
        logic seen;
        seen   = 1'b0;
        lat    = 0;
        err_at = 1'b0;
        other  = 1'b0;
        en_all = 1'b1;
        @(posedge ref_clk);
        while (!seen && lat < 100) begin
            @(negedge ref_clk);
            lat++;
            en_all = en_all & o_clk_en;
            seen   = (id == 0) ? o_ack0 : o_ack1;
            if (!seen && ((id == 0) ? o_ack1 : o_ack0)) other = 1'b1;
            err_at = o_err;
        end
        chk("ack_seen", seen, 1'b1);
        @(posedge ref_clk);
        #1;
        if (id == 0) i_req0 = 1'b0;
        else         i_req1 = 1'b0;
    endtask

    task automatic requester(input int id, input int n);
        int           gap;
        logic [W-1:0] r;
        logic         seen;
        for (int k = 0; k < n; k++) begin
            gap = $urandom_range(0, 6);
            repeat (gap) begin
                @(posedge ref_clk);
                #1;
            end
            r = W'($urandom_range(0, 9));
            if ($urandom_range(0, 7) == 0) r = W'($urandom_range(0, 255));
            if (id == 0) begin
                i_ratio0 = r;
                i_req0   = 1'b1;
            end else begin
                i_ratio1 = r;
                i_req1   = 1'b1;
            end
            seen = 1'b0;
            for (int w = 0; w < 300 && !seen; w++) begin
                @(negedge ref_clk);
                seen = (id == 0) ? o_ack0 : o_ack1;
            end
            chk("rand_ack", seen, 1'b1);
            @(posedge ref_clk);
            #1;
            if (id == 0) i_req0 = 1'b0;
            else         i_req1 = 1'b0;
        end
    endtask

    task automatic directed();
        int   lat;
        logic err_at, other, en_all;

        @(posedge ref_clk);
        #1;
        chk("en_after_rst", o_clk_en, 1'b1);

        // Single change to 8.
        i_ratio0 = 8'd8;
        i_req0   = 1'b1;
        wait_ack(0, lat, err_at, other, en_all);
        chk("lat_change", lat, G + S + 2);
        chk("ratio_now_8", o_div_ratio, 8);
        chk("en_after_ack", o_clk_en, 1'b1);

        // Simultaneous pair: requester 0 first.
        i_ratio0 = 8'd32;
        i_ratio1 = 8'd8;
        i_req0   = 1'b1;
        i_req1   = 1'b1;
        wait_ack(0, lat, err_at, other, en_all);
        chk("pair0_lat", lat, G + S + 2);
        chk("pair0_order", other, 1'b0);
        chk("pair0_ratio", o_div_ratio, 32);
        wait_ack(1, lat, err_at, other, en_all);
        chk("pair1_lat", lat, G + S + 2);
        chk("pair_final", o_div_ratio, 8);

        // Next simultaneous pair: requester 1 first.
        i_ratio0 = 8'd5;
        i_ratio1 = 8'd7;
        i_req0   = 1'b1;
        i_req1   = 1'b1;
        wait_ack(1, lat, err_at, other, en_all);
        chk("rr_order", other, 1'b0);
        chk("rr_ratio", o_div_ratio, 7);
        wait_ack(0, lat, err_at, other, en_all);
        chk("rr_final", o_div_ratio, 5);

        // Same ratio: immediate ack, enable undisturbed.
        i_ratio0 = 8'd5;
        i_req0   = 1'b1;
        wait_ack(0, lat, err_at, other, en_all);
        chk("same_lat", lat, 1);
        chk("same_en_high", en_all, 1'b1);

        // Reset while draining.
        i_ratio0 = 8'd20;
        i_req0   = 1'b1;
        @(posedge ref_clk);
        @(posedge ref_clk);
        #2;
        i_rst = 1'b1;
        model_reset();
        #1;
        check_reset_outputs("drain_rst");
        repeat (2) @(posedge ref_clk);
        #1;
        i_rst = 1'b0;
        wait_ack(0, lat, err_at, other, en_all);
        chk("rereq_lat", lat, G + S + 2);
        chk("rereq_ratio", o_div_ratio, 20);

        // Ratio 1: rejected with the check enabled, loaded otherwise.
        i_ratio1 = 8'd1;
        i_req1   = 1'b1;
        wait_ack(1, lat, err_at, other, en_all);
        chk("r1_lat", lat, CHECK_EN ? 1 : (G + S + 2));
        chk("r1_err", err_at, CHECK_EN);
        chk("r1_ratio", o_div_ratio, CHECK_EN ? 20 : 1);
    endtask

    initial begin
        done      = 1'b0;
        rand_stop = 1'b0;
        i_rst     = 1'b1;
        i_en      = 1'b1;
        i_req0    = 1'b0;
        i_req1    = 1'b0;
        i_ratio0  = '0;
        i_ratio1  = '0;
        model_reset();
        repeat (3) @(posedge ref_clk);
        #1;
        check_reset_outputs("rst");
        i_rst = 1'b0;

        fork
            begin
                while (!done) begin
                    @(posedge ref_clk);
                    model_step();
                    @(negedge ref_clk);
                    cycle_checks();
                end
            end
            begin
                directed();
                fork
                    begin
                        fork
                            requester(0, 40);
                            requester(1, 40);
                        join
                        rand_stop = 1'b1;
                    end
                    begin
                        while (!rand_stop) begin
                            repeat ($urandom_range(1, 15)) @(posedge ref_clk);
                            #1;
                            i_en = 1'($urandom_range(0, 1));
                        end
                    end
                join
                repeat (12) @(posedge ref_clk);
                done = 1'b1;
            end
        join

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
